handshake_sync_rx: RTL and testbench



---
 rtl/handshake_sync_rx.sv | 128 ++++++++++++
 tb/tb_handshake_sync_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/handshake_sync_rx.sv
// handshake_sync_rx
//   Clocked receiver for a two-phase bundled-data asynchronous pipeline stage.
//   The upstream request is synchronised into clk. Each new request phase
//   captures data_in into a small FIFO and returns the acknowledge phase.
//   The FIFO contents are presented as a first-word-fall-through valid/ready
//   stream. When the FIFO is full, acknowledges are withheld so that the
//   upstream stage stalls.
//
// Ports
//   clk        clock
//   rst        asynchronous active-low reset
//   req_in     two-phase request (one transition per token)
//   data_in    bundled data, stable from before req_in toggles until ack_out toggles
//   ack_out    two-phase acknowledge, toggles once per captured token
//   out_data   head-of-FIFO data (holds its last value while empty)
//   out_valid  FIFO non-empty
//   out_ready  downstream accepts the head on out_valid && out_ready
//   count      FIFO occupancy
module handshake_sync_rx #(
  parameter int DATA_W      = 3,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   phase_q, phase_d;
  logic                   ack_q, ack_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   valid_q, valid_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];

  logic req_s;
  logic pending;
  logic do_wr;
  logic do_rd;

  always_comb begin
    // Shift chain: bit 0 takes the raw request, the top bit is the synchronised level.
    sync_d  = {sync_q[SYNC_STAGES-2:0], req_in};
    req_s   = sync_q[SYNC_STAGES-1];

    // A token is waiting whenever the synchronised level differs from the
    // level of the last token we accepted.
    pending = (req_s != phase_q);

    // Fullness is judged on the pre-edge count, so a read on the same edge
    // does not free room for a capture until the following edge.
    do_wr   = pending && (count_q < CNT_W'(DEPTH));
    do_rd   = (count_q != '0) && out_ready;

    phase_d  = phase_q ^ do_wr;
    ack_d    = phase_d;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);

    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    valid_d = (count_d != '0);

    // Registered head: look ahead to the entry the read pointer will point
    // at after this edge. If that entry is the one being written right now,
    // the memory does not hold it yet, so take it straight from data_in.
    // While the FIFO becomes/stays empty the last value is held.
    out_data_d = out_data_q;
    if (count_d != '0) begin
      if (do_wr && (wr_ptr_q == rd_ptr_d)) begin
        out_data_d = data_in;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      phase_q    <= 1'b0;
      ack_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      sync_q     <= sync_d;
      phase_q    <= phase_d;
      ack_q      <= ack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage has no reset: occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign ack_out   = ack_q;
  assign out_valid = valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_handshake_sync_rx.sv
module tb_handshake_sync_rx;

  localparam int DATA_W = 3;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst;
  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  int n_checks;
  int n_fail;

  handshake_sync_rx #(
    .DATA_W(DATA_W),
    .DEPTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .data_in  (data_in),
    .ack_out  (ack_out),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Toggle the request with new data and wait (bounded) for the matching ack.
  // Called right after a falling edge; returns on the falling edge where ack matched.
  task automatic send_token(input logic [DATA_W-1:0] v, input string tag);
    data_in = v;
    req_in  = ~req_in;
    for (int i = 0; i < 10 && ack_out != req_in; i++) @(negedge clk);
    check(tag, 32'(ack_out), 32'(req_in));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    req_in    = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack_out), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_data", 32'(out_data), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ack", 32'(ack_out), 0);
    check("post_rst_valid", 32'(out_valid), 0);

    // ---------------- single token: ack two edges after sampling ----------------
    data_in = 3'd1;
    req_in  = 1'b1;
    @(negedge clk);
    check("single_ack_e1", 32'(ack_out), 0);
    @(negedge clk);
    check("single_ack_e2", 32'(ack_out), 0);
    check("single_valid_e2", 32'(out_valid), 0);
    @(negedge clk);
    check("single_ack_e3", 32'(ack_out), 1);
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 1);
    check("single_count", 32'(count), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("single_drain_count", 32'(count), 0);
    check("single_drain_valid", 32'(out_valid), 0);
    check("single_hold_data", 32'(out_data), 1);

    // ---------------- stream 1,2,3 with out_ready=1 ----------------
    out_ready = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      send_token(DATA_W'(v), "stream_ack");
      check("stream_valid", 32'(out_valid), 1);
      check("stream_data", 32'(out_data), 32'(v));
    end
    @(negedge clk);
    check("stream_end_count", 32'(count), 0);
    check("stream_end_valid", 32'(out_valid), 0);
    check("stream_ack_level", 32'(ack_out), 0);

    // ---------------- full backpressure ----------------
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      send_token(DATA_W'(v), "full_ack");
      check("full_count", 32'(count), 32'(v));
    end
    data_in = 3'd5;
    req_in  = ~req_in;
    repeat (6) @(negedge clk);
    check("full_no_ack", 32'(ack_out != req_in), 1);
    check("full_count4", 32'(count), 4);
    check("full_head", 32'(out_data), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("full_read_count", 32'(count), 3);
    check("full_read_no_ack", 32'(ack_out != req_in), 1);
    check("full_read_head", 32'(out_data), 2);
    @(negedge clk);
    check("full_late_ack", 32'(ack_out), 32'(req_in));
    check("full_late_count", 32'(count), 4);

    // ---------------- simultaneous capture and read ----------------
    // FIFO holds 2,3,4,5; drain two to leave 4,5.
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    check("sim_pre_count", 32'(count), 2);
    check("sim_pre_head", 32'(out_data), 4);
    data_in = 3'd6;
    req_in  = ~req_in;
    repeat (2) @(negedge clk);
    check("sim_pre_ack", 32'(ack_out != req_in), 1);
    out_ready = 1'b1;               // asserted for the capture edge only
    @(negedge clk);
    out_ready = 1'b0;
    check("sim_ack", 32'(ack_out), 32'(req_in));
    check("sim_count", 32'(count), 2);
    check("sim_head", 32'(out_data), 5);
    out_ready = 1'b1;
    @(negedge clk);
    check("sim_next_head", 32'(out_data), 6);
    check("sim_next_count", 32'(count), 1);
    @(negedge clk);
    check("sim_empty", 32'(count), 0);

    // ---------------- pointer wrap across 8 more tokens ----------------
    for (int v = 0; v < 8; v++) begin
      send_token(DATA_W'(7 - v), "wrap_ack");
      check("wrap_data", 32'(out_data), 32'(7 - v));
    end
    @(negedge clk);
    check("wrap_end_count", 32'(count), 0);

    // ---------------- mid-operation asynchronous reset ----------------
    out_ready = 1'b0;
    send_token(3'd7, "mid_ack");
    send_token(3'd1, "mid_ack");
    send_token(3'd2, "mid_ack");
    check("mid_count", 32'(count), 3);
    check("mid_valid", 32'(out_valid), 1);
    #2;
    rst    = 1'b0;
    req_in = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_ack", 32'(ack_out), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_post_ack", 32'(ack_out), 0);
    check("mid_post_count", 32'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
